// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Takes symbolic instructions (op, rd, rs1, rs2, byte immediate) over a
// valid/ready handshake, encodes each into a 32-bit RV32I word, range-checks
// the immediate and writes the word to instruction memory at consecutive
// word addresses starting at BASE_ADDR. It is used by the boot/test path to
// fill instruction memory before the core is released.
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset (wins over clear_i)
//   clear_i       synchronous soft restart: back to idle, address/count/error cleared
//   in_valid_i    instruction request valid
//   in_ready_o    encoder can accept a request (idle only)
//   in_op_i       00=ADD 01=LW 10=SW 11=BEQ
//   in_rd_i       destination register (ADD, LW)
//   in_rs1_i      source 1 / base register
//   in_rs2_i      source 2 (ADD, SW, BEQ)
//   in_imm_i      signed byte immediate / branch byte offset
//   in_last_i     final instruction of the program
//   mem_we_o      write strobe, held until mem_ack_i
//   mem_addr_o    byte address of the current word
//   mem_wdata_o   encoded instruction word
//   mem_ack_i     memory accepted the write this cycle
//   done_o        program complete (last word written or DEPTH reached)
//   full_o        DEPTH words written
//   error_o       sticky encoding error
//   err_code_o    00 none, 01 immediate out of range, 10 branch offset odd
//   count_o       number of words written
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [1:0]                   in_op_i,
  input  logic [4:0]                   in_rd_i,
  input  logic [4:0]                   in_rs1_i,
  input  logic [4:0]                   in_rs2_i,
  input  logic [31:0]                  in_imm_i,
  input  logic                         in_last_i,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic                         mem_ack_i,
  output logic                         done_o,
  output logic                         full_o,
  output logic                         error_o,
  output logic [1:0]                   err_code_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Symbolic operation codes on in_op_i
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Error codes reported on err_code_o
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ODD   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          rs1_q, rs1_d;
  logic [4:0]          rs2_q, rs2_d;
  logic [31:0]         imm_q, imm_d;
  logic                last_q, last_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                error_q, error_d;
  logic [1:0]          errCode_q, errCode_d;

  logic [31:0]         encWord;
  logic [1:0]          encErr;
  logic signed [31:0]  immS;
  logic                immFitsI;
  logic                immFitsB;
  logic [CNT_W-1:0]    countInc;
  logic                depthHit;

  // Immediate range checks work on the latched immediate as a signed value.
  // I/S-type immediates are 12-bit signed; the branch offset is a 13-bit
  // signed byte offset whose LSB must be zero, so its top legal value is 4094.
  assign immS     = $signed(imm_q);
  assign immFitsI = (immS >= -32'sd2048) && (immS <= 32'sd2047);
  assign immFitsB = (immS >= -32'sd4096) && (immS <= 32'sd4094);

  // Word encoder: scatters the latched fields into the RV32I layout of the
  // selected format. Fields an operation does not use are simply not placed.
  always_comb begin
    encWord = 32'd0;
    case (op_q)
      OP_ADD: encWord = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, OPC_OP};
      OP_LW:  encWord = {imm_q[11:0], rs1_q, 3'b010, rd_q, OPC_LOAD};
      OP_SW:  encWord = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], OPC_STORE};
      default: encWord = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                          imm_q[4:1], imm_q[11], OPC_BRANCH};
    endcase
  end

  // Encoding checks. ADD carries no immediate and never fails. For BEQ an odd
  // offset is reported as such even when it is also out of range, because
  // the odd bit can never be encoded regardless of magnitude.
  always_comb begin
    encErr = ERR_NONE;
    case (op_q)
      OP_LW, OP_SW: begin
        if (!immFitsI) begin
          encErr = ERR_RANGE;
        end
      end
      OP_ADD: begin
        encErr = ERR_NONE;
      end
      default: begin
        if (imm_q[0]) begin
          encErr = ERR_ODD;
        end else if (!immFitsB) begin
          encErr = ERR_RANGE;
        end
      end
    endcase
  end

  // Count after the write in flight is acknowledged, and whether that write
  // fills the last slot. The address can never wrap because this stops the
  // loader first.
  assign countInc = count_q + CNT_ONE;
  assign depthHit = (countInc == DEPTH_CNT);

  // Next-state logic: every register holds by default; each state only
  // touches what it owns. Done and error states are terminal until a
  // reset or clear.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    last_d    = last_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    count_d   = count_q;
    full_d    = full_q;
    error_d   = error_q;
    errCode_d = errCode_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          op_d    = in_op_i;
          rd_d    = in_rd_i;
          rs1_d   = in_rs1_i;
          rs2_d   = in_rs2_i;
          imm_d   = in_imm_i;
          last_d  = in_last_i;
          state_d = S_ENC;
        end
      end

      S_ENC: begin
        if (encErr != ERR_NONE) begin
          error_d   = 1'b1;
          errCode_d = encErr;
          state_d   = S_ERR;
        end else begin
          wdata_d = encWord;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (mem_ack_i) begin
          count_d = countInc;
          addr_d  = addr_q + WORD_STEP;
          if (depthHit) begin
            full_d = 1'b1;
          end
          if (last_q || depthHit) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset and clear share one restart target,
  // so reset's priority over clear needs no separate branch. A restart during
  // a write abandons it: the strobe drops and the word is not counted.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      rd_q      <= 5'd0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      imm_q     <= 32'd0;
      last_q    <= 1'b0;
      wdata_q   <= 32'd0;
      addr_q    <= BASE;
      count_q   <= '0;
      full_q    <= 1'b0;
      error_q   <= 1'b0;
      errCode_q <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      last_q    <= last_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      error_q   <= error_d;
      errCode_q <= errCode_d;
    end
  end

  // Handshake and status outputs decode directly from the state so the
  // strobe and ready flags change exactly on state transitions.
  assign in_ready_o  = (state_q == S_IDLE);
  assign mem_we_o    = (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign full_o      = full_q;
  assign error_o     = error_q;
  assign err_code_o  = errCode_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// Testbench for instr_encoder_loader (DEPTH=4 so the full condition is
// reachable quickly). A reference model predicts each written word from the
// RV32I field layout and the expected address from the number of words
// written; a monitor compares every cycle. Directed scenarios add literal
// expectations for latency, status flags and specific encodings.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 0;
  localparam int CNT_W     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              inValid = 1'b0;
  logic              inReady;
  logic [1:0]        inOp = 2'b00;
  logic [4:0]        inRd = 5'd0;
  logic [4:0]        inRs1 = 5'd0;
  logic [4:0]        inRs2 = 5'd0;
  logic [31:0]       inImm = 32'd0;
  logic              inLast = 1'b0;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              memAck = 1'b0;
  logic              done;
  logic              full;
  logic              error;
  logic [1:0]        errCode;
  logic [CNT_W-1:0]  count;

  int          nChecks = 0;
  int          nFails = 0;
  logic [31:0] expWords[$];
  int          modelCount = 0;
  bit          checkEn = 1'b0;
  logic [31:0] capWord[0:15];
  int          weSeen = 0;
  int          ackDelay = 0;
  bit          ackEnable = 1'b1;

  instr_encoder_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .clear_i(clear),
    .in_valid_i(inValid),
    .in_ready_o(inReady),
    .in_op_i(inOp),
    .in_rd_i(inRd),
    .in_rs1_i(inRs1),
    .in_rs2_i(inRs2),
    .in_imm_i(inImm),
    .in_last_i(inLast),
    .mem_we_o(memWe),
    .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata),
    .mem_ack_i(memAck),
    .done_o(done),
    .full_o(full),
    .error_o(error),
    .err_code_o(errCode),
    .count_o(count)
  );

  always #5 clk = ~clk;

  // Reference encoding built from the instruction-format field positions.
  function automatic logic [31:0] modelWord(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
    int w;
    case (op)
      0: w = 'h33 | (rd << 7) | (rs1 << 15) | (rs2 << 20);
      1: w = 'h03 | (rd << 7) | (2 << 12) | (rs1 << 15) | ((imm & 'hFFF) << 20);
      2: w = 'h23 | ((imm & 'h1F) << 7) | (2 << 12) | (rs1 << 15) | (rs2 << 20)
             | (((imm >> 5) & 'h7F) << 25);
      default: w = 'h63 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 'hF) << 8)
             | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 'h3F) << 25)
             | (((imm >> 12) & 1) << 31);
    endcase
    return 32'(w);
  endfunction

  // Reference error code: 0 none, 1 out of range, 2 odd branch offset.
  function automatic int modelErr(input int op, input int imm);
    if (op == 1 || op == 2) return (imm < -2048 || imm > 2047) ? 1 : 0;
    if (op == 3) begin
      if ((imm & 1) != 0) return 2;
      return (imm < -4096 || imm > 4094) ? 1 : 0;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int op, input int rd, input int rs1, input int rs2,
                               input int imm, input bit last, input int bound,
                               output bit accepted);
    inValid  = 1'b1;
    inOp     = 2'(op);
    inRd     = 5'(rd);
    inRs1    = 5'(rs1);
    inRs2    = 5'(rs2);
    inImm    = 32'(imm);
    inLast   = last;
    accepted = 1'b0;
    for (int i = 0; i < bound && !accepted; i++) begin
      if (inReady === 1'b1) accepted = 1'b1;
      tick();
    end
    inValid = 1'b0;
    if (accepted && modelErr(op, imm) == 0)
      expWords.push_back(modelWord(op, rd, rs1, rs2, imm));
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic waitCount(input int val, input int bound);
    int n = 0;
    while (int'(count) != val && n < bound) begin
      tick();
      n++;
    end
    checkOutput("wait_count", 32'(count), 32'(val));
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checkOutput("wait_done", 32'(done), 1);
  endtask

  // One request after a clear; code 0 means a normal immediate-ack write.
  task automatic runCase(input string name, input int op, input int imm, input int code);
    bit acc;
    doClear();
    weSeen = 0;
    applyStimulus(op, 5, 2, 6, imm, 1'b0, 10, acc);
    checkOutput({name, "_accepted"}, 32'(acc), 1);
    repeat (3) tick();
    checkOutput({name, "_error"}, 32'(error), (code != 0) ? 1 : 0);
    checkOutput({name, "_err_code"}, 32'(errCode), 32'(code));
    checkOutput({name, "_count"}, 32'(count), (code != 0) ? 0 : 1);
    checkOutput({name, "_writes"}, 32'(weSeen), (code != 0) ? 0 : 1);
    checkOutput({name, "_ready"}, 32'(inReady), (code != 0) ? 0 : 1);
  endtask

  // Memory responder: acknowledges after ackDelay strobe cycles.
  initial begin
    int weRun = 0;
    forever begin
      @(posedge clk);
      #1;
      if (memWe === 1'b1 && ackEnable) begin
        memAck = (weRun >= ackDelay);
        weRun++;
      end else begin
        memAck = 1'b0;
        weRun  = 0;
      end
    end
  end

  // Monitor: every cycle compare count/full to the model and any write
  // against the next expected word at the model's address.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("count", 32'(count), 32'(modelCount));
        checkOutput("full", 32'(full), (modelCount == DEPTH) ? 1 : 0);
        if (memWe === 1'b1) begin
          weSeen++;
          if (expWords.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected_write: got mem_we=1 addr 0x%02h data 0x%08h, expected no write",
                     memAddr, memWdata);
          end else begin
            checkOutput("mem_addr", 32'(memAddr), 32'(BASE_ADDR + 4 * modelCount));
            checkOutput("mem_wdata", memWdata, expWords[0]);
          end
        end
        if (reset || clear) begin
          modelCount = 0;
          expWords.delete();
        end else if (memWe === 1'b1 && memAck && expWords.size() > 0) begin
          capWord[modelCount] = memWdata;
          void'(expWords.pop_front());
          modelCount++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_ready", 32'(inReady), 1);
    checkOutput("rst_we", 32'(memWe), 0);
    checkOutput("rst_addr", 32'(memAddr), 32'(BASE_ADDR));
    checkOutput("rst_wdata", memWdata, 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_error", 32'(error), 0);
    checkOutput("rst_err_code", 32'(errCode), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkEn = 1'b1;

    // LW x5,8(x2), immediate ack: latency N -> N+2 strobe -> N+3 ready
    $display("[TB] LW latency");
    applyStimulus(1, 5, 2, 0, 8, 1'b0, 10, acc);
    checkOutput("lw_accepted", 32'(acc), 1);
    checkOutput("lw_enc_we", 32'(memWe), 0);
    checkOutput("lw_enc_ready", 32'(inReady), 0);
    tick();
    checkOutput("lw_we", 32'(memWe), 1);
    checkOutput("lw_addr", 32'(memAddr), 0);
    checkOutput("lw_wdata", memWdata, 32'h00812283);
    tick();
    checkOutput("lw_ready_after", 32'(inReady), 1);
    checkOutput("lw_count", 32'(count), 1);
    checkOutput("lw_we_after", 32'(memWe), 0);
    checkOutput("lw_addr_after", 32'(memAddr), 4);

    // SW / BEQ / ADD(last) program
    $display("[TB] three-word program");
    doClear();
    applyStimulus(2, 0, 2, 6, -4, 1'b0, 10, acc);
    applyStimulus(3, 0, 1, 2, 8, 1'b0, 10, acc);
    applyStimulus(0, 3, 1, 2, 0, 1'b1, 10, acc);
    waitDone(20);
    checkOutput("prog_count", 32'(count), 3);
    checkOutput("prog_full", 32'(full), 0);
    checkOutput("prog_ready", 32'(inReady), 0);
    checkOutput("prog_addr", 32'(memAddr), 32'h0C);
    checkOutput("prog_word0", capWord[0], 32'hFE612E23);
    checkOutput("prog_word1", capWord[1], 32'h00208463);
    checkOutput("prog_word2", capWord[2], 32'h002081B3);

    // Delayed ack: strobe held 4 cycles, one count increment
    $display("[TB] delayed ack");
    doClear();
    ackDelay = 3;
    weSeen = 0;
    applyStimulus(1, 5, 2, 0, 8, 1'b0, 10, acc);
    waitCount(1, 20);
    repeat (2) tick();
    checkOutput("dly_we_cycles", 32'(weSeen), 4);
    checkOutput("dly_count", 32'(count), 1);
    checkOutput("dly_word", capWord[0], 32'h00812283);
    ackDelay = 0;

    // Error and boundary immediates
    $display("[TB] range checks");
    runCase("beq_odd", 3, 3, 2);
    runCase("beq_odd_big", 3, 4095, 2);
    runCase("beq_big", 3, 4096, 1);
    runCase("beq_min", 3, -4096, 0);
    runCase("lw_2048", 1, 2048, 1);
    runCase("sw_m2049", 2, -2049, 1);
    runCase("sw_2047", 2, 2047, 0);
    runCase("add_anyimm", 0, 32'h7FFF_FFFF, 0);
    runCase("lw_m2048", 1, -2048, 0);
    checkOutput("lw_m2048_word", capWord[0], 32'h80012283);

    // DEPTH limit: four writes fill the memory, fifth never accepted
    $display("[TB] depth limit");
    doClear();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i + 1, 1, 2, 0, 1'b0, 10, acc);
      checkOutput("depth_accepted", 32'(acc), 1);
    end
    waitDone(20);
    checkOutput("depth_full", 32'(full), 1);
    checkOutput("depth_count", 32'(count), 4);
    checkOutput("depth_ready", 32'(inReady), 0);
    checkOutput("depth_addr", 32'(memAddr), 32'h10);
    applyStimulus(0, 9, 1, 2, 0, 1'b0, 6, acc);
    checkOutput("depth_fifth_rejected", 32'(acc), 0);
    checkOutput("depth_count_hold", 32'(count), 4);

    // Reset during a write aborts it
    $display("[TB] reset mid-write");
    doClear();
    ackEnable = 1'b0;
    applyStimulus(1, 5, 2, 0, 8, 1'b0, 10, acc);
    tick();
    checkOutput("abort_we_before", 32'(memWe), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_we", 32'(memWe), 0);
    checkOutput("abort_count", 32'(count), 0);
    checkOutput("abort_addr", 32'(memAddr), 32'(BASE_ADDR));
    checkOutput("abort_ready", 32'(inReady), 1);
    ackEnable = 1'b1;
    applyStimulus(1, 7, 3, 0, 16, 1'b0, 10, acc);
    waitCount(1, 20);
    checkOutput("abort_new_word", capWord[0], 32'h0101A383);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the datapath's immediate/field extraction. Accepts symbolic instructions (op, rd, rs1, rs2, byte immediate) over a valid/ready handshake and encodes each into a 32-bit RV32I word. Range-checks the immediate and writes the word to instruction memory at sequential word addresses. Used by the testbench/boot path to fill instruction memory before the core runs.

Parameters:
ADDR_W, 8, instruction-memory byte-address width.
DEPTH, 64, maximum words written per program; DEPTH*4 <= 2^ADDR_W.
BASE_ADDR, 0, byte address of the first word; word-aligned.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high.
clear  input  1  synchronous soft restart: back to IDLE, address/count/error cleared.
in_valid  input  1  instruction request valid.
in_ready  output  1  encoder can accept a request.
in_op  input  2  00=ADD (R-type), 01=LW, 10=SW, 11=BEQ.
in_rd  input  5  destination register (ADD, LW only).
in_rs1  input  5  source 1 / base register.
in_rs2  input  5  source 2 (ADD, SW, BEQ only).
in_imm  input  32  signed byte immediate / branch byte offset.
in_last  input  1  marks final instruction of the program.
mem_we  output  1  write strobe, held until mem_ack.
mem_addr  output  ADDR_W  byte address of current word.
mem_wdata  output  32  encoded instruction.
mem_ack  input  1  memory accepted the write this cycle.
done  output  1  program complete (last written or DEPTH reached).
full  output  1  DEPTH words written.
error  output  1  sticky encoding error.
err_code  output  2  00 none, 01 imm out of range, 10 branch offset odd.
count  output  $clog2(DEPTH+1)  words written.

Behaviour:
- Reset/clear: state IDLE; in_ready=1; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; done=full=error=0; err_code=00; count=0. Reset and clear mid-WRITE abort the write: mem_we drops the next cycle and the word is not counted. Reset has priority over clear.
- States: IDLE -> ENC -> WRITE -> IDLE / DONE; ENC -> ERR on a check failure.
- IDLE: in_ready=1. On in_valid & in_ready, latch all in_* fields and go to ENC. in_ready=0 in every other state.
- ENC (1 cycle): encode the word and run the range checks.
  - ADD: funct7=0, funct3=000, opcode 0110011.
  - LW: imm[11:0], rs1, funct3 010, rd, opcode 0000011.
  - SW: imm[11:5], rs2, rs1, 010, imm[4:0], opcode 0100011.
  - BEQ: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], opcode 1100011.
  - Range checks. LW/SW: -2048..2047. BEQ: -4096..4094 and imm[0]=0; an odd offset gives code 10 even if also out of range. ADD ignores imm and never errors.
  - Unused fields are ignored.
- Check failure: go to ERR with error=1 and err_code set. Nothing is written. Stay in ERR until reset/clear.
- WRITE: mem_we=1. mem_addr and mem_wdata stay stable until the cycle mem_ack=1.
- On ack: mem_we=0 next cycle, count+1, mem_addr+4.
  - If latched last=1 or the new count==DEPTH, go to DONE.
  - Otherwise go to IDLE.
  - The DEPTH limit sets full=1.
- Latency: request accepted cycle N, ENC N+1, mem_we=1 in N+2. With ack in N+2, in_ready=1 again in N+3. Throughput is one word per 3 cycles.
- DONE: done=1, in_ready=0; held until reset/clear. ERR holds likewise.
- mem_ack outside WRITE is ignored. The address never wraps, because DEPTH blocks it first.

Test Plan:
- LW x5,8(x2): op=01 rd=5 rs1=2 imm=8, ack immediately -> mem_we in cycle N+2, mem_wdata=0x00812283, mem_addr=0x00, count=1, in_ready=1 at N+3.
- Sequence SW x6,-4(x2); BEQ x1,x2,+8; ADD x3,x1,x2 (last=1) -> words 0xFE612E23 @0x00, 0x00208463 @0x04, 0x002081B3 @0x08; done=1, count=3, full=0, in_ready=0.
- mem_ack delayed 3 cycles on LW -> mem_we held 4 cycles, addr/wdata stable, count increments exactly once.
- Errors:
  - BEQ imm=3 -> error=1, err_code=10, no mem_we.
  - After clear, LW imm=2048 -> err_code=01, no write.
  - After clear, LW imm=-2048 -> writes 0x80012283 (rs1=2, rd=5).
- DEPTH=4, five requests, last=0 -> writes at 0x00,0x04,0x08,0x0C; after the 4th ack: done=1, full=1, in_ready=0; 5th request never accepted.
- Reset asserted while mem_we=1 (ack withheld) -> next cycle mem_we=0, count=0, mem_addr=BASE_ADDR, IDLE; a new request encodes normally.
